// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: compares the last PAT_W qualified bits
// against a loadable pattern, pulses o_led on a match and counts matches (saturating).
module seq_detect_param #(
  parameter int unsigned       PAT_W     = 4,
  parameter int unsigned       CNT_W     = 8,
  parameter logic [PAT_W-1:0]  RESET_PAT = 4'b1010
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_pat_load,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic             i_overlap,
  input  logic             i_valid,
  input  logic             i_btn,
  output logic             o_led,
  output logic [CNT_W-1:0] o_match_count
);

  localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

  // The oldest history bit never takes part in a compare (the window is the
  // newest PAT_W-1 bits plus the incoming bit), so only PAT_W-1 bits are kept.
  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              led_q,  led_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic [PAT_W-1:0]  window;
  logic              accept;
  logic              hit;

  assign window = {hist_q, i_btn};
  assign accept = i_valid & ~i_clear & ~i_pat_load;
  assign hit    = accept && (fill_q >= FILL_ARM) && (window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    led_d  = 1'b0;
    cnt_d  = cnt_q;
    if (i_clear) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (i_pat_load) begin
      pat_d  = i_pattern;
      fill_d = '0;
    end else if (accept) begin
      hist_d = window[PAT_W-2:0];
      if (hit) begin
        led_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Non-overlapping mode restarts the fill; stale history is masked by fill_q.
        fill_d = i_overlap ? FILL_FULL : '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pat_q  <= RESET_PAT;
      hist_q <= '0;
      fill_q <= '0;
      led_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      led_q  <= led_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_led         = led_q;
  assign o_match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three instances share stimulus
// (default, 2-bit counter with 1111 reset pattern, 1-bit counter).
module tb_seq_detect_param;

  logic       i_clock = 1'b0;
  logic       i_reset_n;
  logic       i_clear;
  logic       i_pat_load;
  logic [3:0] i_pattern;
  logic       i_overlap;
  logic       i_valid;
  logic       i_btn;

  logic       led_a, led_b, led_c;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [0:0] cnt_c;

  int n_chk = 0;
  int n_bad = 0;

  always #5 i_clock = ~i_clock;

  seq_detect_param #(.PAT_W(4), .CNT_W(8), .RESET_PAT(4'b1010)) u_a (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_clear(i_clear), .i_pat_load(i_pat_load),
    .i_pattern(i_pattern), .i_overlap(i_overlap), .i_valid(i_valid), .i_btn(i_btn),
    .o_led(led_a), .o_match_count(cnt_a));

  seq_detect_param #(.PAT_W(4), .CNT_W(2), .RESET_PAT(4'b1111)) u_b (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_clear(i_clear), .i_pat_load(i_pat_load),
    .i_pattern(i_pattern), .i_overlap(i_overlap), .i_valid(i_valid), .i_btn(i_btn),
    .o_led(led_b), .o_match_count(cnt_b));

  seq_detect_param #(.PAT_W(4), .CNT_W(1), .RESET_PAT(4'b1010)) u_c (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_clear(i_clear), .i_pat_load(i_pat_load),
    .i_pattern(i_pattern), .i_overlap(i_overlap), .i_valid(i_valid), .i_btn(i_btn),
    .o_led(led_c), .o_match_count(cnt_c));

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given qualifier/data; returns 1 time unit after the edge.
  task automatic cyc(input logic vld, input logic btn);
    i_valid = vld;
    i_btn   = btn;
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    cyc(1'b1, 1'b1);
    i_clear = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] pat);
    i_pat_load = 1'b1;
    i_pattern  = pat;
    cyc(1'b1, 1'b0);
    i_pat_load = 1'b0;
  endtask

  // Vectors are written in stream order: the MSB of the n-bit field is the first cycle.
  task automatic run_seq(input string tag, input int n, input logic [15:0] btn,
                         input logic [15:0] vld, input logic [15:0] led, input int sel);
    for (int i = 0; i < n; i++) begin
      int idx = n - 1 - i;
      cyc(vld[idx], btn[idx]);
      check_val($sformatf("%s_led%0d", tag, i + 1),
                int'(sel == 0 ? led_a : led_b), int'(led[idx]));
    end
  endtask

  initial begin
    i_reset_n  = 1'b0;
    i_clear    = 1'b0;
    i_pat_load = 1'b0;
    i_pattern  = 4'b0000;
    i_overlap  = 1'b1;
    i_valid    = 1'b0;
    i_btn      = 1'b0;
    #2;
    check_val("rst_led", int'(led_a), 0);
    check_val("rst_cnt", int'(cnt_a), 0);
    @(posedge i_clock);
    #1 i_reset_n = 1'b1;

    run_seq("basic", 4, 16'b1010, 16'b1111, 16'b0001, 0);
    check_val("basic_cnt", int'(cnt_a), 1);
    do_clear();
    check_val("clr_cnt", int'(cnt_a), 0);
    check_val("clr_led", int'(led_a), 0);

    i_overlap = 1'b1;
    run_seq("ovl", 12, 16'b1010_1001_0101, 16'b1111_1111_1111, 16'b0001_0100_0010, 0);
    check_val("ovl_cnt", int'(cnt_a), 3);
    do_clear();

    i_overlap = 1'b0;
    run_seq("novl", 12, 16'b1010_1001_0101, 16'b1111_1111_1111, 16'b0001_0000_0010, 0);
    check_val("novl_cnt", int'(cnt_a), 2);
    do_clear();

    i_overlap = 1'b1;
    run_seq("gap", 8, 16'b1101_1101, 16'b1010_1010, 16'b0000_0010, 0);
    check_val("gap_cnt", int'(cnt_a), 1);
    do_clear();

    run_seq("preload", 7, 16'b101_0101, 16'b111_1111, 16'b000_1010, 0);
    check_val("preload_cnt", int'(cnt_a), 2);
    do_load(4'b0110);
    check_val("load_led", int'(led_a), 0);
    check_val("load_cnt", int'(cnt_a), 2);
    run_seq("newpat", 4, 16'b0110, 16'b1111, 16'b0001, 0);
    check_val("newpat_cnt", int'(cnt_a), 3);

    i_clear = 1'b1;
    do_load(4'b1111);
    i_clear = 1'b0;
    check_val("ldclr_cnt", int'(cnt_a), 0);
    run_seq("keptpat", 4, 16'b0110, 16'b1111, 16'b0001, 0);
    check_val("keptpat_cnt", int'(cnt_a), 1);

    do_clear();
    do_load(4'b1111);
    run_seq("sat", 8, 16'b1111_1111, 16'b1111_1111, 16'b0001_1111, 1);
    check_val("sat_cnt_b", int'(cnt_b), 3);
    check_val("sat_cnt_a", int'(cnt_a), 5);
    check_val("sat_cnt_c", int'(cnt_c), 1);

    do_load(4'b1010);
    check_val("load_keep_cnt", int'(cnt_a), 5);
    run_seq("prerst", 3, 16'b101, 16'b111, 16'b000, 0);
    #2 i_reset_n = 1'b0;
    #1;
    check_val("arst_cnt_a", int'(cnt_a), 0);
    check_val("arst_cnt_b", int'(cnt_b), 0);
    check_val("arst_led", int'(led_a), 0);
    @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    run_seq("postrst0", 1, 16'b0, 16'b1, 16'b0, 0);
    run_seq("postrst", 4, 16'b1010, 16'b1111, 16'b0001, 0);
    check_val("postrst_cnt", int'(cnt_a), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
